// File: rtl/uart_pkg.sv
// Shared types for the configurable UART receiver: FSM state encoding,
// parity_mode encodings and the 3-sample majority vote.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP1  = 3'd4,
        ST_STOP2  = 3'd5
    } uart_state_e;

    localparam logic [1:0] PAR_NONE    = 2'd0;
    localparam logic [1:0] PAR_EVEN    = 2'd1;
    localparam logic [1:0] PAR_ODD     = 2'd2;
    localparam logic [1:0] PAR_NONE_HI = 2'd3;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-clk tick every max(div,1) cycles,
// counter cleared by restart so the first tick lands div cycles later.
module uart_baud_tick #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             restart,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;
    logic [DIV_W-1:0] div_m1;

    // >= rather than == so a divider shrinking mid-count cannot strand the counter
    always_comb begin
        div_m1 = (div == '0) ? '0 : div - DIV_W'(1);
        tick   = (cnt_q >= div_m1);
        cnt_d  = cnt_q + DIV_W'(1);
        if (restart || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: oversampled majority-vote bit recovery,
// optional parity, 1/2 stop bits, held output word with overrun detection.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int DIV_W      = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx_in,
    input  logic [DIV_W-1:0]     baud_div,
    input  logic [1:0]           parity_mode,
    input  logic                 two_stop,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun_err,
    output logic                 busy,
    output uart_state_e          state_dbg
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [TW-1:0] SAMP0  = TW'(OVERSAMPLE / 2 - 2);
    localparam logic [TW-1:0] SAMP1  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] VOTE   = TW'(OVERSAMPLE / 2);
    localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

    // Reset: asserts asynchronously, releases on a clock edge
    logic [1:0] rst_sync_q;
    logic [1:0] rst_sync_d;
    logic       rst_n;

    logic rx_meta_q, rx_meta_d;
    logic rx_sync_q, rx_sync_d;
    logic rx_prev_q, rx_prev_d;

    uart_state_e          state_q, state_d;
    logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [1:0]           samp_q, samp_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_flag_q, par_flag_d;
    logic                 frm_flag_q, frm_flag_d;
    logic                 armed_q, armed_d;
    logic                 done_q, done_d;
    logic [1:0]           par_mode_q, par_mode_d;
    logic                 two_stop_q, two_stop_d;
    logic [DIV_W-1:0]     div_q, div_d;

    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 parity_err_q, parity_err_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;

    logic             tick;
    logic             restart;
    logic [DIV_W-1:0] tick_div;
    logic             vote_tick;
    logic             voted;
    logic             par_en;
    logic             exp_par;

    assign rst_sync_d = {rst_sync_q[0], 1'b1};
    assign rst_n      = rst_sync_q[1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= rst_sync_d;
        end
    end

    // Live divider while idle keeps the free-running tick; latched copy once framing
    assign tick_div = (state_q == ST_IDLE) ? baud_div : div_q;

    uart_baud_tick #(
        .DIV_W(DIV_W)
    ) u_baud_tick (
        .clk    (clk),
        .reset  (rst_n),
        .restart(restart),
        .div    (tick_div),
        .tick   (tick)
    );

    assign vote_tick = tick && (tick_cnt_q == VOTE);
    assign voted     = maj3(samp_q[1], samp_q[0], rx_sync_q);
    assign par_en    = (par_mode_q == PAR_EVEN) || (par_mode_q == PAR_ODD);
    assign exp_par   = (par_mode_q == PAR_ODD) ? ~(^shift_q) : ^shift_q;

    always_comb begin
        rx_meta_d    = rx_in;
        rx_sync_d    = rx_meta_q;
        rx_prev_d    = rx_sync_q;
        state_d      = state_q;
        tick_cnt_d   = tick_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        samp_d       = samp_q;
        shift_d      = shift_q;
        par_flag_d   = par_flag_q;
        frm_flag_d   = frm_flag_q;
        armed_d      = armed_q;
        done_d       = 1'b0;
        par_mode_d   = par_mode_q;
        two_stop_d   = two_stop_q;
        div_d        = div_q;
        restart      = 1'b0;
        rx_data_d    = rx_data_q;
        rx_valid_d   = rx_valid_q;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        overrun_d    = 1'b0;

        // Tick counter runs through bit boundaries; states advance at the vote tick
        if (tick && (state_q != ST_IDLE)) begin
            tick_cnt_d = (tick_cnt_q == T_LAST) ? '0 : tick_cnt_q + TW'(1);
            if ((tick_cnt_q == SAMP0) || (tick_cnt_q == SAMP1)) begin
                samp_d = {samp_q[0], rx_sync_q};
            end
        end

        case (state_q)
            ST_IDLE: begin
                // After reset or a low stop bit, need a high line at a tick before arming
                if (!armed_q) begin
                    if (tick && rx_sync_q) begin
                        armed_d = 1'b1;
                    end
                end else if (rx_prev_q && !rx_sync_q) begin
                    state_d    = ST_START;
                    restart    = 1'b1;
                    tick_cnt_d = '0;
                    bit_cnt_d  = '0;
                    shift_d    = '0;
                    par_flag_d = 1'b0;
                    frm_flag_d = 1'b0;
                    par_mode_d = parity_mode;
                    two_stop_d = two_stop;
                    div_d      = baud_div;
                end
            end
            ST_START: begin
                if (vote_tick) begin
                    state_d = voted ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (vote_tick) begin
                    shift_d = {voted, shift_q[DATA_BITS-1:1]};
                    if (bit_cnt_q == B_LAST) begin
                        state_d = par_en ? ST_PARITY : ST_STOP1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (vote_tick) begin
                    if (voted != exp_par) begin
                        par_flag_d = 1'b1;
                    end
                    state_d = ST_STOP1;
                end
            end
            ST_STOP1, ST_STOP2: begin
                if (vote_tick) begin
                    if (!voted) begin
                        frm_flag_d = 1'b1;
                    end
                    if ((state_q == ST_STOP1) && two_stop_q) begin
                        state_d = ST_STOP2;
                    end else begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                        if (!voted) begin
                            armed_d = 1'b0;
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Output holding register: a completion against an unaccepted word is dropped
        if (done_q) begin
            if (rx_valid_q && !rx_ready) begin
                overrun_d = 1'b1;
            end else begin
                rx_data_d    = shift_q;
                parity_err_d = par_flag_q;
                frame_err_d  = frm_flag_q;
                rx_valid_d   = 1'b1;
            end
        end else if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q    <= 1'b1;
            rx_sync_q    <= 1'b1;
            rx_prev_q    <= 1'b1;
            state_q      <= ST_IDLE;
            tick_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            samp_q       <= 2'b11;
            shift_q      <= '0;
            par_flag_q   <= 1'b0;
            frm_flag_q   <= 1'b0;
            armed_q      <= 1'b0;
            done_q       <= 1'b0;
            par_mode_q   <= PAR_NONE;
            two_stop_q   <= 1'b0;
            div_q        <= '0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            rx_meta_q    <= rx_meta_d;
            rx_sync_q    <= rx_sync_d;
            rx_prev_q    <= rx_prev_d;
            state_q      <= state_d;
            tick_cnt_q   <= tick_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            samp_q       <= samp_d;
            shift_q      <= shift_d;
            par_flag_q   <= par_flag_d;
            frm_flag_q   <= frm_flag_d;
            armed_q      <= armed_d;
            done_q       <= done_d;
            par_mode_q   <= par_mode_d;
            two_stop_q   <= two_stop_d;
            div_q        <= div_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign parity_err  = parity_err_q;
    assign frame_err   = frame_err_q;
    assign overrun_err = overrun_q;
    assign busy        = (state_q != ST_IDLE);
    assign state_dbg   = state_q;

endmodule
